// File: rtl/plaintext_block_packer.sv
// Packs a byte stream into 64-bit blocks; out_valid one cycle after the completing byte, in_ready drops while the output slot is stalled.
// PKCS_PAD_EN: PKCS#7-style padding with a trailing all-pad block; otherwise zero padding.
module plaintext_block_packer #(
  parameter int BLOCK_BYTES = 8,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_byte,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [8*BLOCK_BYTES-1:0] out_block,
  output logic [3:0]               out_nbytes,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         blk_count
);

  localparam int BW    = 8 * BLOCK_BYTES;
  localparam int IDX_W = $clog2(BLOCK_BYTES);

  typedef enum logic {S_FILL, S_FLUSH} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [BW-1:0]    r_acc;
  logic [BW-1:0]    r_out_block;
  logic [3:0]       r_out_nbytes;
  logic             r_out_last;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_blk_count;

  logic             w_accept;
  logic             w_full;
  logic             w_complete;
  logic             w_slot_free;
  logic             w_drain;
  logic             w_flush_load;
  logic             w_blk_last;
  logic             w_to_flush;
  logic [7:0]       w_pad;
  logic [3:0]       w_nbytes;
  logic [BW-1:0]    w_blk_nxt;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_drain     = r_out_valid && out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_full      = (r_idx == IDX_W'(BLOCK_BYTES - 1));
  assign w_complete  = w_accept && (w_full || in_last);
  assign w_nbytes    = 4'(int'(r_idx) + 1);

`ifdef PKCS_PAD_EN
  assign w_pad      = 8'(BLOCK_BYTES - 1 - int'(r_idx));
  assign w_blk_last = in_last && !w_full;
  assign w_to_flush = in_last && w_full;
`else
  assign w_pad      = 8'h00;
  assign w_blk_last = in_last;
  assign w_to_flush = 1'b0;
`endif

  // Block image as it will leave: stored bytes, the incoming byte, then pad.
  always_comb begin
    w_blk_nxt = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (k < int'(r_idx))
        w_blk_nxt[BW-1-8*k -: 8] = r_acc[BW-1-8*k -: 8];
      else if (k == int'(r_idx))
        w_blk_nxt[BW-1-8*k -: 8] = in_byte;
      else
        w_blk_nxt[BW-1-8*k -: 8] = w_pad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_FILL;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_complete && w_to_flush) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_slot_free) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    in_ready     = !rst && (r_state == S_FILL) && w_slot_free;
    w_flush_load = (r_state == S_FLUSH) && w_slot_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_complete) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_idx                           <= r_idx + IDX_W'(1);
      r_acc[BW-1-8*int'(r_idx) -: 8] <= in_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_block  <= '0;
      r_out_nbytes <= '0;
      r_out_last   <= 1'b0;
      r_out_valid  <= 1'b0;
    end else if (w_complete) begin
      r_out_block  <= w_blk_nxt;
      r_out_nbytes <= w_nbytes;
      r_out_last   <= w_blk_last;
      r_out_valid  <= 1'b1;
    end else if (w_flush_load) begin
      r_out_block  <= {BLOCK_BYTES{8'(BLOCK_BYTES)}};
      r_out_nbytes <= 4'd0;
      r_out_last   <= 1'b1;
      r_out_valid  <= 1'b1;
    end else if (w_drain) begin
      r_out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_blk_count <= '0;
    else if (w_drain)
      r_blk_count <= r_blk_count + CNT_W'(1);
  end

  assign out_block  = r_out_block;
  assign out_nbytes = r_out_nbytes;
  assign out_last   = r_out_last;
  assign out_valid  = r_out_valid;
  assign blk_count  = r_blk_count;

endmodule
